commit_ctrl: RTL and testbench
==============================

Name: commit_ctrl

Overview:
- In-order retirement sequencer between the ROB head and the architectural state.
- Pops completed head entries one at a time and drives the register file commit port (commit_ready/commit_reg_id/commit_val/commit_rob_id).
- Serialises store retirement against the memory-side store handshake.
- Raises the global clear pulse and redirect PC on mispredicted control flow.
- Latches a sticky halt.

Parameters:
ROB_WIDTH, 3, ROB index width; must equal the global `ROB_WIDTH`.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low freezes all state and suppresses pops
head_valid  input  1  ROB head occupied and execution complete
head_type  input  2  0=REG (ALU/load/jal/jalr), 1=BRANCH, 2=STORE, 3=HALT
head_rd  input  5  destination register (0 = no write)
head_val  input  32  result value
head_rob_id  input  ROB_WIDTH  ROB index of head
head_mispredict  input  1  control-flow outcome differs from prediction
head_target  input  32  correct next PC
head_pop  output  1  combinational; ROB advances head this cycle
commit_ready  output  1  registered one-cycle regfile write strobe
commit_reg_id  output  5  registered
commit_val  output  32  registered
commit_rob_id  output  ROB_WIDTH  registered
store_go  output  1  registered one-cycle pulse; LSB may write memory
store_done  input  1  LSB reports store completed
clear  output  1  registered one-cycle flush to all modules incl. regfile
redirect_valid  output  1  registered; same cycle as clear
redirect_pc  output  32  registered; valid while redirect_valid
halt  output  1  sticky after HALT retires
retired_cnt  output  32  retired instruction count

Behaviour:
- Reset values: state=RUN; all outputs 0; retired_cnt=0.
- rdy_in low: head_pop=0; every register holds, including one-cycle pulses (they resume on the next rdy_in high cycle).
- States: RUN, STORE_WAIT, FLUSH, HALTED.
- head_pop = rdy_in && state==RUN && head_valid && !rst_in.
- Pop in cycle N means the retire effects below are visible in cycle N+1 for exactly one cycle.
- REG pop:
  - commit_ready=1 only if head_rd!=0; commit_reg_id/val/rob_id = head fields.
  - rd=0 pops with commit_ready=0.
  - If head_mispredict=1 (jalr): also clear=1, redirect_valid=1, redirect_pc=head_target; next state FLUSH.
- BRANCH pop:
  - No regfile write.
  - If head_mispredict=1: clear/redirect as above, next state FLUSH; else stay RUN.
- STORE pop: store_go=1 at N+1; next state STORE_WAIT.
- STORE_WAIT:
  - No pops.
  - store_done=1 returns to RUN the following cycle.
  - store_done at N+1 (same cycle as store_go) is accepted.
- FLUSH:
  - Lasts exactly one cycle after the clear cycle (bubble for ROB/RS to empty).
  - No pops; clear=0.
  - Then RUN.
- HALT pop: halt=1 from N+1; state HALTED permanently until reset; no further pops.
- retired_cnt increments by 1 on every pop (all types, incl. HALT); wraps 0xFFFFFFFF -> 0.
- Back-to-back REG pops produce commit_ready high on consecutive cycles with fresh fields each cycle.
- Reset mid-STORE_WAIT or FLUSH: returns to RUN and clears all pulses in the same cycle; a pending store_done is ignored.
- clear and commit_ready may be high in the same cycle (jalr link write); the regfile's clear-priority decides.

Decomposition:
- Shared defines package: head_type encodings (TYPE_REG/BRANCH/STORE/HALT) and the state encoding; `ROB_WIDTH` stays in the global defines.
- Single module; no sub-module is warranted.

Test Plan:
- REG head rd=5, val=0x1234, rob_id=2, valid in cycle 10 -> head_pop@10; commit_ready=1, reg_id=5, val=0x1234, rob_id=2 @11 only; retired_cnt=1.
- Three REG heads on consecutive cycles, rd=1,0,3 -> commit_ready pattern 1,0,1 on cycles N+1..N+3; retired_cnt=3.
- STORE head @10, store_done held 0 until 14 -> store_go @11 only; head_pop=0 on 11..14 even with head_valid; next pop @15.
- BRANCH mispredict target=0x100 @10 -> clear=1, redirect_valid=1, redirect_pc=0x100 @11; no pop @11-12; pop resumes @13.
- jalr REG mispredict rd=1, val=0x44 -> commit_ready and clear both high @N+1.
- rdy_in low for 3 cycles while the STORE pulse is pending -> store_go emitted the first rdy_in-high cycle. HALT head -> halt stays 1 and head_pop=0 forever. Assert rst_in -> halt=0, state RUN.

Source files
------------

// File: rtl/commit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : commit_ctrl_pkg
//  Purpose  : Shared encodings for the in-order retirement sequencer:
//             ROB head instruction classes and commit FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package commit_ctrl_pkg;

    // Instruction class presented at the ROB head
    localparam logic [1:0] TYPE_REG    = 2'd0;  // ALU / load / jal / jalr
    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;
    localparam logic [1:0] TYPE_HALT   = 2'd3;

    // Retirement sequencer states
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_HALTED     = 2'd3
    } state_t;

endpackage : commit_ctrl_pkg
`default_nettype wire

// File: rtl/commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : commit_ctrl
//  Purpose  : In-order retirement sequencer. Pops completed ROB head entries
//             one at a time, drives the register-file commit port, serialises
//             store retirement against the LSB handshake, raises clear and
//             redirect on mispredicted control flow, and latches a sticky halt.
//  Revision : 1.0 - initial release
// ============================================================================
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    // Must match the global ROB_WIDTH define used by the ROB.
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    input  logic                 head_valid,
    input  logic [1:0]           head_type,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_val,
    input  logic [ROB_WIDTH-1:0] head_rob_id,
    input  logic                 head_mispredict,
    input  logic [31:0]          head_target,
    output logic                 head_pop,

    output logic                 commit_ready,
    output logic [4:0]           commit_reg_id,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_rob_id,

    output logic                 store_go,
    input  logic                 store_done,

    output logic                 clear,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,

    output logic                 halt,
    output logic [31:0]          retired_cnt
);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_pop;
    logic                   w_commit_ready_nxt;
    logic                   w_load_fields;
    logic                   w_store_go_nxt;
    logic                   w_flush_nxt;
    logic                   w_halt_set;

    logic                   r_commit_ready;
    logic [4:0]             r_commit_reg_id;
    logic [31:0]            r_commit_val;
    logic [ROB_WIDTH-1:0]   r_commit_rob_id;
    logic                   r_store_go;
    logic                   r_clear;
    logic                   r_redirect_valid;
    logic [31:0]            r_redirect_pc;
    logic                   r_halt;
    logic [31:0]            r_retired_cnt;

    // Pop decision and next-state / next-pulse decode. In FLUSH the registered
    // clear marks the clear cycle; the cycle after it is the empty bubble.
    always_comb begin
        w_state_nxt        = r_state;
        w_pop              = rdy_in && (r_state == ST_RUN) && head_valid && !rst_in;
        w_commit_ready_nxt = 1'b0;
        w_load_fields      = 1'b0;
        w_store_go_nxt     = 1'b0;
        w_flush_nxt        = 1'b0;
        w_halt_set         = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_pop) begin
                    case (head_type)
                        TYPE_REG: begin
                            w_load_fields      = 1'b1;
                            w_commit_ready_nxt = (head_rd != 5'd0);
                            if (head_mispredict) begin
                                w_flush_nxt = 1'b1;
                                w_state_nxt = ST_FLUSH;
                            end
                        end
                        TYPE_BRANCH: begin
                            if (head_mispredict) begin
                                w_flush_nxt = 1'b1;
                                w_state_nxt = ST_FLUSH;
                            end
                        end
                        TYPE_STORE: begin
                            w_store_go_nxt = 1'b1;
                            w_state_nxt    = ST_STORE_WAIT;
                        end
                        default: begin
                            w_halt_set  = 1'b1;
                            w_state_nxt = ST_HALTED;
                        end
                    endcase
                end
            end
            ST_STORE_WAIT: begin
                if (store_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!r_clear) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_HALTED;
            end
        endcase
    end

    // State and output registers; rdy_in low freezes everything, pulses included.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state          <= ST_RUN;
            r_commit_ready   <= 1'b0;
            r_commit_reg_id  <= 5'd0;
            r_commit_val     <= 32'd0;
            r_commit_rob_id  <= '0;
            r_store_go       <= 1'b0;
            r_clear          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_halt           <= 1'b0;
            r_retired_cnt    <= 32'd0;
        end else if (rdy_in) begin
            r_state          <= w_state_nxt;
            r_commit_ready   <= w_commit_ready_nxt;
            r_store_go       <= w_store_go_nxt;
            r_clear          <= w_flush_nxt;
            r_redirect_valid <= w_flush_nxt;
            r_halt           <= r_halt | w_halt_set;
            r_retired_cnt    <= r_retired_cnt + {31'd0, w_pop};
            if (w_load_fields) begin
                r_commit_reg_id <= head_rd;
                r_commit_val    <= head_val;
                r_commit_rob_id <= head_rob_id;
            end
            if (w_flush_nxt) begin
                r_redirect_pc <= head_target;
            end
        end
    end

    assign head_pop       = w_pop;
    assign commit_ready   = r_commit_ready;
    assign commit_reg_id  = r_commit_reg_id;
    assign commit_val     = r_commit_val;
    assign commit_rob_id  = r_commit_rob_id;
    assign store_go       = r_store_go;
    assign clear          = r_clear;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign halt           = r_halt;
    assign retired_cnt    = r_retired_cnt;

endmodule : commit_ctrl
`default_nettype wire

// File: tb/tb_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_ctrl
//  Purpose  : Directed, table-driven bench for commit_ctrl. Each record is one
//             clock cycle of head/handshake inputs, the expected head_pop in
//             that cycle, and the expected registered outputs after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_commit_ctrl;

    localparam int RW = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          head_valid;
    logic [1:0]    head_type;
    logic [4:0]    head_rd;
    logic [31:0]   head_val;
    logic [RW-1:0] head_rob_id;
    logic          head_mispredict;
    logic [31:0]   head_target;
    logic          head_pop;
    logic          commit_ready;
    logic [4:0]    commit_reg_id;
    logic [31:0]   commit_val;
    logic [RW-1:0] commit_rob_id;
    logic          store_go;
    logic          store_done;
    logic          clear;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          halt;
    logic [31:0]   retired_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    commit_ctrl #(.ROB_WIDTH(RW)) u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .head_valid      (head_valid),
        .head_type       (head_type),
        .head_rd         (head_rd),
        .head_val        (head_val),
        .head_rob_id     (head_rob_id),
        .head_mispredict (head_mispredict),
        .head_target     (head_target),
        .head_pop        (head_pop),
        .commit_ready    (commit_ready),
        .commit_reg_id   (commit_reg_id),
        .commit_val      (commit_val),
        .commit_rob_id   (commit_rob_id),
        .store_go        (store_go),
        .store_done      (store_done),
        .clear           (clear),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .retired_cnt     (retired_cnt)
    );

    typedef struct {
        logic        rst, rdy, vld;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [RW-1:0] rob;
        logic        mis;
        logic [31:0] tgt;
        logic        sd;
        logic        e_pop, e_cr;
        logic [4:0]  e_rid;
        logic [31:0] e_val;
        logic [RW-1:0] e_rob;
        logic        e_sg, e_clr, e_rv;
        logic [31:0] e_rpc;
        logic        e_hlt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input int rst, input int rdy, input int vld, input int typ, input int rd,
        input int val, input int rob, input int mis, input int tgt, input int sd,
        input int pop, input int cr, input int rid, input int cval, input int crob,
        input int sg, input int clr, input int rv, input int rpc, input int hlt,
        input int cnt);
        vec_t v;
        v.rst = 1'(rst);  v.rdy = 1'(rdy);  v.vld = 1'(vld);  v.typ = 2'(typ);
        v.rd = 5'(rd);    v.val = 32'(val); v.rob = RW'(rob); v.mis = 1'(mis);
        v.tgt = 32'(tgt); v.sd = 1'(sd);
        v.e_pop = 1'(pop); v.e_cr = 1'(cr); v.e_rid = 5'(rid); v.e_val = 32'(cval);
        v.e_rob = RW'(crob); v.e_sg = 1'(sg); v.e_clr = 1'(clr); v.e_rv = 1'(rv);
        v.e_rpc = 32'(rpc); v.e_hlt = 1'(hlt); v.e_cnt = 32'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_in = v.rst; rdy_in = v.rdy; head_valid = v.vld; head_type = v.typ;
        head_rd = v.rd; head_val = v.val; head_rob_id = v.rob;
        head_mispredict = v.mis; head_target = v.tgt; store_done = v.sd;
    endtask

    initial begin
        vec_t v;
        int   w;
        int   bad;

        //          rst rdy vld typ rd  val     rob mis tgt     sd | pop cr rid val     rob sg clr rv rpc     hlt cnt
        tbl.push_back(mk(1,1,1,0, 5,'h1234,2,0,0,    0, 0,0, 0,0,     0,0,0,0,0,     0, 0)); // reset
        tbl.push_back(mk(0,1,0,0, 0,0,     0,0,0,    0, 0,0, 0,0,     0,0,0,0,0,     0, 0));
        tbl.push_back(mk(0,1,1,0, 5,'h1234,2,0,0,    0, 1,1, 5,'h1234,2,0,0,0,0,     0, 1)); // REG rd5
        tbl.push_back(mk(0,1,0,0, 0,0,     0,0,0,    0, 0,0, 5,'h1234,2,0,0,0,0,     0, 1));
        tbl.push_back(mk(0,1,1,0, 1,'hA,   3,0,0,    0, 1,1, 1,'hA,   3,0,0,0,0,     0, 2)); // b2b rd1
        tbl.push_back(mk(0,1,1,0, 0,'hB,   4,0,0,    0, 1,0, 0,'hB,   4,0,0,0,0,     0, 3)); // rd0
        tbl.push_back(mk(0,1,1,0, 3,'hC,   5,0,0,    0, 1,1, 3,'hC,   5,0,0,0,0,     0, 4)); // rd3
        tbl.push_back(mk(0,1,1,2, 0,0,     6,0,0,    0, 1,0, 3,'hC,   5,1,0,0,0,     0, 5)); // STORE
        tbl.push_back(mk(0,1,1,0, 7,'h77,  7,0,0,    0, 0,0, 3,'hC,   5,0,0,0,0,     0, 5));
        tbl.push_back(mk(0,1,1,0, 7,'h77,  7,0,0,    0, 0,0, 3,'hC,   5,0,0,0,0,     0, 5));
        tbl.push_back(mk(0,1,1,0, 7,'h77,  7,0,0,    1, 0,0, 3,'hC,   5,0,0,0,0,     0, 5)); // done
        tbl.push_back(mk(0,1,1,0, 7,'h77,  7,0,0,    0, 1,1, 7,'h77,  7,0,0,0,0,     0, 6));
        tbl.push_back(mk(0,1,1,2, 0,0,     0,0,0,    1, 1,0, 7,'h77,  7,1,0,0,0,     0, 7)); // STORE
        tbl.push_back(mk(0,1,1,0, 2,'h22,  1,0,0,    1, 0,0, 7,'h77,  7,0,0,0,0,     0, 7)); // done w/ go
        tbl.push_back(mk(0,1,1,0, 2,'h22,  1,0,0,    0, 1,1, 2,'h22,  1,0,0,0,0,     0, 8));
        tbl.push_back(mk(0,1,1,1, 0,0,     0,1,'h100,0, 1,0, 2,'h22,  1,0,1,1,'h100, 0, 9)); // BR mis
        tbl.push_back(mk(0,1,1,0, 4,'h40,  2,0,0,    0, 0,0, 2,'h22,  1,0,0,0,'h100, 0, 9));
        tbl.push_back(mk(0,1,1,0, 4,'h40,  2,0,0,    0, 0,0, 2,'h22,  1,0,0,0,'h100, 0, 9));
        tbl.push_back(mk(0,1,1,0, 4,'h40,  2,0,0,    0, 1,1, 4,'h40,  2,0,0,0,'h100, 0,10));
        tbl.push_back(mk(0,1,1,1, 0,0,     3,0,'h200,0, 1,0, 4,'h40,  2,0,0,0,'h100, 0,11)); // BR ok
        tbl.push_back(mk(0,1,1,0, 6,'h66,  3,0,0,    0, 1,1, 6,'h66,  3,0,0,0,'h100, 0,12));
        tbl.push_back(mk(0,1,1,0, 1,'h44,  4,1,'h300,0, 1,1, 1,'h44,  4,0,1,1,'h300, 0,13)); // jalr
        tbl.push_back(mk(0,1,1,0, 8,'h88,  5,0,0,    0, 0,0, 1,'h44,  4,0,0,0,'h300, 0,13));
        tbl.push_back(mk(0,1,1,0, 8,'h88,  5,0,0,    0, 0,0, 1,'h44,  4,0,0,0,'h300, 0,13));
        tbl.push_back(mk(0,1,1,2, 0,0,     6,0,0,    0, 1,0, 1,'h44,  4,1,0,0,'h300, 0,14)); // STORE
        tbl.push_back(mk(0,0,1,0, 8,'h88,  5,0,0,    1, 0,0, 1,'h44,  4,1,0,0,'h300, 0,14)); // rdy low
        tbl.push_back(mk(0,0,1,0, 8,'h88,  5,0,0,    1, 0,0, 1,'h44,  4,1,0,0,'h300, 0,14));
        tbl.push_back(mk(0,0,1,0, 8,'h88,  5,0,0,    1, 0,0, 1,'h44,  4,1,0,0,'h300, 0,14));
        tbl.push_back(mk(0,1,1,0, 8,'h88,  5,0,0,    0, 0,0, 1,'h44,  4,0,0,0,'h300, 0,14));
        tbl.push_back(mk(0,1,1,0, 8,'h88,  5,0,0,    1, 0,0, 1,'h44,  4,0,0,0,'h300, 0,14));
        tbl.push_back(mk(0,1,1,3, 0,0,     5,0,0,    0, 1,0, 1,'h44,  4,0,0,0,'h300, 1,15)); // HALT
        tbl.push_back(mk(0,1,1,0, 8,'h88,  5,0,0,    0, 0,0, 1,'h44,  4,0,0,0,'h300, 1,15));
        tbl.push_back(mk(0,1,1,0, 8,'h88,  5,0,0,    0, 0,0, 1,'h44,  4,0,0,0,'h300, 1,15));
        tbl.push_back(mk(1,1,1,0, 8,'h88,  5,0,0,    0, 0,0, 0,0,     0,0,0,0,0,     0, 0)); // reset
        tbl.push_back(mk(0,1,1,0, 9,'h99,  6,0,0,    0, 1,1, 9,'h99,  6,0,0,0,0,     0, 1));
        tbl.push_back(mk(0,1,1,2, 0,0,     7,0,0,    0, 1,0, 9,'h99,  6,1,0,0,0,     0, 2)); // STORE
        tbl.push_back(mk(1,1,1,0, 0,0,     0,0,0,    1, 0,0, 0,0,     0,0,0,0,0,     0, 0)); // rst in wait
        tbl.push_back(mk(0,1,1,0,10,'hA0,  1,0,0,    0, 1,1,10,'hA0,  1,0,0,0,0,     0, 1));
        tbl.push_back(mk(0,0,1,0,11,'hB0,  2,0,0,    0, 0,1,10,'hA0,  1,0,0,0,0,     0, 1)); // rdy low RUN
        tbl.push_back(mk(0,1,0,0, 0,0,     0,0,0,    0, 0,0,10,'hA0,  1,0,0,0,0,     0, 1));
        tbl.push_back(mk(0,1,1,1, 0,0,     0,1,'h400,0, 1,0,10,'hA0,  1,0,1,1,'h400, 0, 2)); // BR mis
        tbl.push_back(mk(1,1,1,0,12,'hC0,  3,0,0,    0, 0,0, 0,0,     0,0,0,0,0,     0, 0)); // rst in flush
        tbl.push_back(mk(0,1,1,0,12,'hC0,  3,0,0,    0, 1,1,12,'hC0,  3,0,0,0,0,     0, 1));

        @(posedge clk_in); #1;
        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v);
            @(negedge clk_in);
            chk("head_pop", i, 32'(head_pop), 32'(v.e_pop));
            @(posedge clk_in); #1;
            chk("commit_ready",   i, 32'(commit_ready),   32'(v.e_cr));
            chk("commit_reg_id",  i, 32'(commit_reg_id),  32'(v.e_rid));
            chk("commit_val",     i, commit_val,          v.e_val);
            chk("commit_rob_id",  i, 32'(commit_rob_id),  32'(v.e_rob));
            chk("store_go",       i, 32'(store_go),       32'(v.e_sg));
            chk("clear",          i, 32'(clear),          32'(v.e_clr));
            chk("redirect_valid", i, 32'(redirect_valid), 32'(v.e_rv));
            chk("redirect_pc",    i, redirect_pc,         v.e_rpc);
            chk("halt",           i, 32'(halt),           32'(v.e_hlt));
            chk("retired_cnt",    i, retired_cnt,         v.e_cnt);
        end

        // Store handshake with a late store_done; the next pop is awaited
        // under a cycle budget. State is RUN, retired_cnt=1 here.
        drive(mk(0,1,1,2,0,0,4,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk_in);
        chk("seq_store_pop", 100, 32'(head_pop), 32'd1);
        @(posedge clk_in); #1;
        chk("seq_store_go", 100, 32'(store_go), 32'd1);
        head_type = 2'd0; head_rd = 5'd13; head_val = 32'hD0; head_rob_id = 3'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("seq_wait_nopop", 101 + k, 32'(head_pop), 32'd0);
            @(posedge clk_in); #1;
        end
        store_done = 1'b1;
        @(posedge clk_in); #1;
        store_done = 1'b0;
        w = 0;
        while (!head_pop && w < 8) begin
            @(posedge clk_in); #1;
            w++;
        end
        chk("seq_resume_latency", 104, 32'(w), 32'd0);
        @(posedge clk_in); #1;
        chk("seq_commit_rd", 105, 32'(commit_reg_id), 32'd13);
        chk("seq_commit_cnt", 105, retired_cnt, 32'd3);

        // Halt is sticky: no pops for many cycles with a valid head.
        head_type = 2'd3;
        @(posedge clk_in); #1;
        head_type = 2'd0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_in);
            if (head_pop || !halt) bad++;
            @(posedge clk_in); #1;
        end
        chk("seq_halt_sticky", 106, 32'(bad), 32'd0);
        chk("seq_halt_cnt", 106, retired_cnt, 32'd4);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("seq_reset_halt", 107, 32'(halt), 32'd0);
        @(negedge clk_in);
        chk("seq_reset_run_pop", 107, 32'(head_pop), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_commit_ctrl
`default_nettype wire
